// File: rtl/sp_stream_reader_pkg.sv
// Shared definitions for the scratchpad read-out path: FSM encoding and the
// element index helper used to address one matrix target.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Operands packed per stored element; this is also the square matrix bound.
  function automatic int unsigned calc_max_dim(input int unsigned bus_width,
                                               input int unsigned data_width);
    return bus_width / data_width;
  endfunction

  function automatic int unsigned sub_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned max_dim);
    return row * max_dim + col;
  endfunction

endpackage

// File: rtl/sp_stream_reader_if.sv
// Valid/ready stream carrying scratchpad elements to the bus read-back path.
interface sp_stream_reader_if #(
  parameter int unsigned BUS_WIDTH = 16
);
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [BUS_WIDTH-1:0] m_data_o;
  logic                 m_last_o;

  modport master (output m_valid_o, output m_data_o, output m_last_o, input  m_ready_i);
  modport slave  (input  m_valid_o, input  m_data_o, input  m_last_o, output m_ready_i);
endinterface

// File: rtl/sp_stream_reader_index_counter.sv
// 2-D row/col fetch counter. A clear restarts at (0,0) in the same cycle, so
// clear and increment together step straight to the successor of (0,0).
module sp_index_counter #(
  parameter int unsigned IDX_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [IDX_W:0]   rows_i,
  input  logic [IDX_W:0]   cols_i,
  input  logic             col_outer_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o
);

  logic [IDX_W-1:0] r_row, r_col;
  logic [IDX_W-1:0] w_row, w_col;
  logic [IDX_W-1:0] w_row_nx, w_col_nx;
  logic             w_row_end, w_col_end;

  assign w_row     = clr_i ? '0 : r_row;
  assign w_col     = clr_i ? '0 : r_col;
  assign w_row_end = ({1'b0, w_row} == rows_i - 1'b1);
  assign w_col_end = ({1'b0, w_col} == cols_i - 1'b1);

  assign row_o  = w_row;
  assign col_o  = w_col;
  assign last_o = w_row_end & w_col_end;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_row_nx = w_row;
    w_col_nx = w_col;
    if (col_outer_i) begin
      if (w_row_end) begin
        w_row_nx = '0;
        w_col_nx = w_col + 1'b1;
      end else begin
        w_row_nx = w_row + 1'b1;
      end
    end else begin
      if (w_col_end) begin
        w_col_nx = '0;
        w_row_nx = w_row + 1'b1;
      end else begin
        w_col_nx = w_col + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (inc_i) begin
      r_row <= w_row_nx;
      r_col <= w_col_nx;
    end else if (clr_i) begin
      r_row <= '0;
      r_col <= '0;
    end
  end

endmodule

// File: rtl/sp_stream_reader.sv
// Scratchpad read-out stage: streams a rows x cols sub-matrix element by element.
// Optional column-major order is enabled by defining SP_STREAM_TRANSPOSE_EN.
module sp_stream_reader
  import matmul_pkg::*;
#(
  parameter  int unsigned BUS_WIDTH   = 16,
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned SP_NTARGETS = 2,
  localparam int unsigned MAX_DIM     = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int unsigned IDX_W       = $clog2(MAX_DIM),
  localparam int unsigned DIM_W       = IDX_W + 1,
  localparam int unsigned SUB_W       = 2 * IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef SP_STREAM_TRANSPOSE_EN
  input  logic                 tr_i,
`endif
  input  logic                 start_i,
  input  logic [1:0]           mat_sel_i,
  input  logic [DIM_W-1:0]     rows_i,
  input  logic [DIM_W-1:0]     cols_i,
  output logic [1:0]           sp_addr_o,
  output logic [SUB_W-1:0]     sp_sub_addr_o,
  input  logic [BUS_WIDTH-1:0] sp_data_i,
  sp_stream_reader_if.master   m,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_e               r_state, w_next;
  logic [1:0]           r_mat_sel;
  logic [DIM_W-1:0]     r_rows, r_cols;
  logic                 r_tr;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_valid, r_last, r_done, r_err;

  logic                 w_legal, w_launch, w_err_req, w_hs, w_load;
  logic                 w_tr_in, w_tr_eff, w_pos_last;
  logic [DIM_W-1:0]     w_rows_eff, w_cols_eff;
  logic [IDX_W-1:0]     w_row, w_col;

`ifdef SP_STREAM_TRANSPOSE_EN
  assign w_tr_in = tr_i;
`else
  assign w_tr_in = 1'b0;
`endif

  assign w_legal   = (rows_i != '0) && (rows_i <= DIM_W'(MAX_DIM)) &&
                     (cols_i != '0) && (cols_i <= DIM_W'(MAX_DIM)) &&
                     (32'(mat_sel_i) < SP_NTARGETS);
  assign w_launch  = !rst_i && (r_state == ST_IDLE) && start_i && w_legal;
  assign w_err_req = (r_state == ST_IDLE) && start_i && !w_legal;
  assign w_hs      = r_valid & m.m_ready_i;
  assign w_load    = w_launch | (w_hs & !r_last);

  // The first element is fetched on the accept edge, so the request drives the address directly.
  assign w_rows_eff = w_launch ? rows_i  : r_rows;
  assign w_cols_eff = w_launch ? cols_i  : r_cols;
  assign w_tr_eff   = w_launch ? w_tr_in : r_tr;

  sp_index_counter #(.IDX_W(IDX_W)) u_fetch_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (w_launch),
    .inc_i       (w_load),
    .rows_i      (w_rows_eff),
    .cols_i      (w_cols_eff),
    .col_outer_i (w_tr_eff),
    .row_o       (w_row),
    .col_o       (w_col),
    .last_o      (w_pos_last)
  );

  assign sp_addr_o     = w_launch ? mat_sel_i : r_mat_sel;
  assign sp_sub_addr_o = SUB_W'(sub_addr(32'(w_row), 32'(w_col), MAX_DIM));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_launch)        w_next = ST_STREAM;
      ST_STREAM: if (w_hs && r_last)  w_next = ST_DONE;
      ST_DONE:                        w_next = ST_IDLE;
      default:                        w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mat_sel <= '0;
      r_rows    <= '0;
      r_cols    <= '0;
      r_tr      <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err  <= w_err_req;
      r_done <= (r_state == ST_DONE);
      if (w_launch) begin
        r_mat_sel <= mat_sel_i;
        r_rows    <= rows_i;
        r_cols    <= cols_i;
        r_tr      <= w_tr_in;
      end
      // Word and last flag change only on load, so both hold through a stall.
      if (w_load) begin
        r_data <= sp_data_i;
        r_last <= w_pos_last;
      end
      if (w_launch)             r_valid <= 1'b1;
      else if (w_hs && r_last)  r_valid <= 1'b0;
    end
  end

  assign m.m_valid_o = r_valid;
  assign m.m_data_o  = r_data;
  assign m.m_last_o  = r_last;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_sp_stream_reader.sv
// Directed bench for sp_stream_reader with a combinational scratchpad model
// whose element value encodes {0xA5, target, row, col}.
module tb_sp_stream_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  mat_sel_i;
  logic [2:0]  rows_i, cols_i;
  logic [1:0]  sp_addr_o;
  logic [3:0]  sp_sub_addr_o;
  logic [31:0] sp_data_i;
  logic        busy_o, done_o, err_o;
`ifdef SP_STREAM_TRANSPOSE_EN
  logic        tr_i;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sp_stream_reader_if #(.BUS_WIDTH(32)) m_if ();

  sp_stream_reader #(.BUS_WIDTH(32), .DATA_WIDTH(8), .SP_NTARGETS(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
`ifdef SP_STREAM_TRANSPOSE_EN
    .tr_i          (tr_i),
`endif
    .start_i       (start_i),
    .mat_sel_i     (mat_sel_i),
    .rows_i        (rows_i),
    .cols_i        (cols_i),
    .sp_addr_o     (sp_addr_o),
    .sp_sub_addr_o (sp_sub_addr_o),
    .sp_data_i     (sp_data_i),
    .m             (m_if),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] elem(input int t, input int r, input int c);
    return {8'hA5, 8'(t), 8'(r), 8'(c)};
  endfunction

  always_comb begin
    sp_data_i = elem(int'(sp_addr_o), int'(sp_sub_addr_o[3:2]), int'(sp_sub_addr_o[1:0]));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".valid"},   32'(m_if.m_valid_o), 32'd0);
    check({tag, ".busy"},    32'(busy_o),         32'd0);
    check({tag, ".done"},    32'(done_o),         32'd0);
    check({tag, ".err"},     32'(err_o),          32'd0);
    check({tag, ".last"},    32'(m_if.m_last_o),  32'd0);
    check({tag, ".data"},    m_if.m_data_o,       32'd0);
    check({tag, ".addr"},    32'(sp_addr_o),      32'd0);
    check({tag, ".subaddr"}, 32'(sp_sub_addr_o),  32'd0);
  endtask

  task automatic pos_of(input int k, input int rows, input int cols, input int tr,
                        output int r, output int c);
    if (tr != 0) begin c = k / rows; r = k % rows; end
    else         begin r = k / cols; c = k % cols; end
  endtask

  task automatic launch(input int t, input int rows, input int cols, input int tr);
    mat_sel_i = 2'(t);
    rows_i    = 3'(rows);
    cols_i    = 3'(cols);
`ifdef SP_STREAM_TRANSPOSE_EN
    tr_i      = tr[0];
`endif
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  // inject: a competing start mid-stream and again in the DONE cycle.
  task automatic run_stream(input int t, input int rows, input int cols, input int tr,
                            input int mode, input int inject);
    int k = 0;
    int cyc = 0;
    int n = rows * cols;
    int r, c, r1, c1;
    launch(t, rows, cols, tr);
    while (k < n && cyc < 200) begin
      m_if.m_ready_i = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (inject != 0) begin
        start_i   = (cyc == 2);
        mat_sel_i = 2'd0;
        rows_i    = 3'd1;
        cols_i    = 3'd1;
      end
      pos_of(k, rows, cols, tr, r, c);
      check($sformatf("s%0d.valid[%0d]", t, k), 32'(m_if.m_valid_o), 32'd1);
      check($sformatf("s%0d.data[%0d]",  t, k), m_if.m_data_o, elem(t, r, c));
      check($sformatf("s%0d.last[%0d]",  t, k), 32'(m_if.m_last_o), 32'(k == n - 1));
      check($sformatf("s%0d.addr[%0d]",  t, k), 32'(sp_addr_o), 32'(t));
      check($sformatf("s%0d.busy[%0d]",  t, k), 32'(busy_o), 32'd1);
      check($sformatf("s%0d.err[%0d]",   t, k), 32'(err_o), 32'd0);
      if (k < n - 1) begin
        pos_of(k + 1, rows, cols, tr, r1, c1);
        check($sformatf("s%0d.sub[%0d]", t, k), 32'(sp_sub_addr_o), 32'(r1 * 4 + c1));
      end
      if (m_if.m_ready_i) k++;
      tick();
      cyc++;
    end
    start_i = 1'b0;
    if (k < n) check("stream_timeout", 32'(k), 32'(n));
    m_if.m_ready_i = 1'b0;
    check("post.valid", 32'(m_if.m_valid_o), 32'd0);
    check("post.busy",  32'(busy_o),         32'd1);
    check("post.done",  32'(done_o),         32'd0);
    if (inject != 0) start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("done.pulse", 32'(done_o),         32'd1);
    check("done.busy",  32'(busy_o),         32'd0);
    check("done.valid", 32'(m_if.m_valid_o), 32'd0);
    check("done.err",   32'(err_o),          32'd0);
    tick();
    check("done.clear", 32'(done_o),         32'd0);
    check("idle.valid", 32'(m_if.m_valid_o), 32'd0);
    check("idle.busy",  32'(busy_o),         32'd0);
  endtask

  task automatic illegal(input string tag, input int t, input int rows, input int cols);
    launch(t, rows, cols, 0);
    check({tag, ".err"},   32'(err_o),          32'd1);
    check({tag, ".valid"}, 32'(m_if.m_valid_o), 32'd0);
    check({tag, ".busy"},  32'(busy_o),         32'd0);
    tick();
    check({tag, ".err_clr"}, 32'(err_o),          32'd0);
    check({tag, ".valid2"},  32'(m_if.m_valid_o), 32'd0);
    check({tag, ".busy2"},   32'(busy_o),         32'd0);
  endtask

  initial begin
    rst_i          = 1'b1;
    start_i        = 1'b0;
    mat_sel_i      = 2'd0;
    rows_i         = 3'd0;
    cols_i         = 3'd0;
    m_if.m_ready_i = 1'b0;
`ifdef SP_STREAM_TRANSPOSE_EN
    tr_i           = 1'b0;
`endif
    tick();
    tick();
    check_idle_outputs("reset");
    rst_i = 1'b0;
    tick();
    check_idle_outputs("after_reset");

    // 4x4 of target 1 at full rate.
    run_stream(1, 4, 4, 0, 0, 0);

    // 2x3 of target 0 with a stalling consumer.
    run_stream(0, 2, 3, 0, 1, 0);

    illegal("rows0",   0, 0, 2);
    illegal("cols5",   0, 2, 5);
    illegal("matsel2", 2, 2, 2);

    // Competing starts during STREAM and DONE are ignored.
    run_stream(1, 4, 4, 0, 0, 1);

    // Reset after the third handshake abandons the stream.
    m_if.m_ready_i = 1'b1;
    launch(0, 4, 4, 0);
    tick();
    tick();
    tick();
    check("pre_rst.valid", 32'(m_if.m_valid_o), 32'd1);
    check("pre_rst.data",  m_if.m_data_o,       elem(0, 0, 3));
    rst_i = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    rst_i = 1'b0;
    tick();
    check_idle_outputs("post_rst");
    m_if.m_ready_i = 1'b0;

    run_stream(1, 1, 1, 0, 0, 0);

`ifdef SP_STREAM_TRANSPOSE_EN
    run_stream(0, 2, 2, 1, 0, 0);
    run_stream(1, 3, 2, 1, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
